regfile_read_2r1w: RTL

// - Register file storage plus two registered read ports; the read end of the

---
 rtl/regfile_read_2r1w.sv | 95 +++++++++
 1 files changed

// File: rtl/regfile_read_2r1w.sv
// Register file with one write port and two registered read ports.
// Register 0 reads as zero. BYPASS selects whether a same-edge write is forwarded to readers.
module regfile_read_2r1w #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 5,
  parameter int unsigned BYPASS     = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  RegWrite,
  input  logic [ADDR_WIDTH-1:0] WriteRegister,
  input  logic [DATA_WIDTH-1:0] WriteData,
  input  logic                  ReadEn1,
  input  logic [ADDR_WIDTH-1:0] ReadRegister1,
  input  logic                  ReadEn2,
  input  logic [ADDR_WIDTH-1:0] ReadRegister2,
  output logic [DATA_WIDTH-1:0] ReadData1,
  output logic                  ReadValid1,
  output logic [DATA_WIDTH-1:0] ReadData2,
  output logic                  ReadValid2
);

  localparam int unsigned NUM_REGS = 2 ** ADDR_WIDTH;
  localparam bit          BYPASS_EN = (BYPASS != 0);

  logic [DATA_WIDTH-1:0] regs [NUM_REGS];
  logic [NUM_REGS-1:0]   wr_en_c;
  logic [DATA_WIDTH-1:0] rd_next1_c;
  logic [DATA_WIDTH-1:0] rd_next2_c;

  // One-hot write enable; entry 0 is never enabled, so register 0 stays zero.
  always_comb begin
    wr_en_c = '0;
    for (int unsigned i = 1; i < NUM_REGS; i++) begin
      wr_en_c[i] = RegWrite && (WriteRegister == ADDR_WIDTH'(i));
    end
  end

  // Read-data selection: zero register, optional forward of the in-flight write, else stored value.
  always_comb begin
    rd_next1_c = regs[ReadRegister1];
    if (ReadRegister1 == '0) begin
      rd_next1_c = '0;
    end else if (BYPASS_EN && RegWrite && (WriteRegister == ReadRegister1)) begin
      rd_next1_c = WriteData;
    end
  end

  always_comb begin
    rd_next2_c = regs[ReadRegister2];
    if (ReadRegister2 == '0) begin
      rd_next2_c = '0;
    end else if (BYPASS_EN && RegWrite && (WriteRegister == ReadRegister2)) begin
      rd_next2_c = WriteData;
    end
  end

  // Storage array.
  always_ff @(posedge clk) begin
    for (int unsigned i = 0; i < NUM_REGS; i++) begin
      if (reset) begin
        regs[i] <= '0;
      end else if (wr_en_c[i]) begin
        regs[i] <= WriteData;
      end
    end
  end

  // Read port 1: data holds when not requested, valid marks a fresh result.
  always_ff @(posedge clk) begin
    if (reset) begin
      ReadData1  <= '0;
      ReadValid1 <= 1'b0;
    end else begin
      ReadValid1 <= ReadEn1;
      if (ReadEn1) begin
        ReadData1 <= rd_next1_c;
      end
    end
  end

  // Read port 2.
  always_ff @(posedge clk) begin
    if (reset) begin
      ReadData2  <= '0;
      ReadValid2 <= 1'b0;
    end else begin
      ReadValid2 <= ReadEn2;
      if (ReadEn2) begin
        ReadData2 <= rd_next2_c;
      end
    end
  end

endmodule
